// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing generator: register indices,
// 640x480 default timing and sync polarity encodings.
package vga_pkg;

    typedef enum logic [2:0] {
        REG_H_ACT = 3'd0,
        REG_H_SS  = 3'd1,
        REG_H_SE  = 3'd2,
        REG_H_TOT = 3'd3,
        REG_V_ACT = 3'd4,
        REG_V_SS  = 3'd5,
        REG_V_SE  = 3'd6,
        REG_V_TOT = 3'd7
    } reg_idx_e;

    localparam int unsigned VGA_H_ACT = 640;
    localparam int unsigned VGA_H_SS  = 656;
    localparam int unsigned VGA_H_SE  = 752;
    localparam int unsigned VGA_H_TOT = 799;
    localparam int unsigned VGA_V_ACT = 480;
    localparam int unsigned VGA_V_SS  = 490;
    localparam int unsigned VGA_V_SE  = 492;
    localparam int unsigned VGA_V_TOT = 524;

    localparam logic POL_ACT_LOW  = 1'b0;
    localparam logic POL_ACT_HIGH = 1'b1;

    function automatic logic sync_level(input logic on, input logic pol);
        return on ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Register write bus of the VGA timing generator.
interface vga_timing_gen_if #(
    parameter int unsigned CW = 12
);
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [CW-1:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus active-area and sync compares.
module vga_axis_counter #(
    parameter int unsigned CW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          inc,
    input  logic [CW-1:0] act,
    input  logic [CW-1:0] ss,
    input  logic [CW-1:0] se,
    input  logic [CW-1:0] tot,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          active,
    output logic          sync_on
);

    // >= rather than == so a total programmed below the count still wraps
    assign wrap    = (cnt >= tot);
    assign active  = (cnt < act);
    assign sync_on = (cnt >= ss) && (cnt < se);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ce && inc) begin
            cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator with shadowed registers, registered
// sync/DE/position outputs and character-cell memory addressing.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CW          = 12,
    parameter int unsigned H_ACT       = VGA_H_ACT,
    parameter int unsigned H_SS        = VGA_H_SS,
    parameter int unsigned H_SE        = VGA_H_SE,
    parameter int unsigned H_TOT       = VGA_H_TOT,
    parameter int unsigned V_ACT       = VGA_V_ACT,
    parameter int unsigned V_SS        = VGA_V_SS,
    parameter int unsigned V_SE        = VGA_V_SE,
    parameter int unsigned V_TOT       = VGA_V_TOT,
    parameter logic        HS_POL      = POL_ACT_LOW,
    parameter logic        VS_POL      = POL_ACT_LOW,
    parameter int unsigned CHAR_W_LOG2 = 3,
    parameter int unsigned CHAR_H_LOG2 = 4,
    parameter int unsigned MA_W        = 14
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   pix_ce,
    vga_timing_gen_if.slave        bus,
    output logic                   HSYNC,
    output logic                   VSYNC,
    output logic                   DE,
    output logic [CW-1:0]          x,
    output logic [CW-1:0]          y,
    output logic [MA_W-1:0]        MA,
    output logic [CHAR_H_LOG2-1:0] RA,
    output logic                   frame_start
);

    localparam logic [CW-1:0] REG_RST [8] = '{
        CW'(H_ACT), CW'(H_SS), CW'(H_SE), CW'(H_TOT),
        CW'(V_ACT), CW'(V_SS), CW'(V_SE), CW'(V_TOT)
    };

    logic [CW-1:0]   shadow [8];
    logic [CW-1:0]   active [8];
    logic [CW-1:0]   h, v;
    logic            h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
    logic            copy;
    logic            de_next;
    logic            ra_max;
    logic [MA_W-1:0] row_base;
    logic [MA_W-1:0] char_cols;

    vga_axis_counter #(.CW(CW)) u_h (
        .clk     (CLK),
        .rst_n   (RSTn),
        .ce      (pix_ce),
        .inc     (1'b1),
        .act     (active[REG_H_ACT]),
        .ss      (active[REG_H_SS]),
        .se      (active[REG_H_SE]),
        .tot     (active[REG_H_TOT]),
        .cnt     (h),
        .wrap    (h_wrap),
        .active  (h_act),
        .sync_on (h_sync)
    );

    vga_axis_counter #(.CW(CW)) u_v (
        .clk     (CLK),
        .rst_n   (RSTn),
        .ce      (pix_ce),
        .inc     (h_wrap),
        .act     (active[REG_V_ACT]),
        .ss      (active[REG_V_SS]),
        .se      (active[REG_V_SE]),
        .tot     (active[REG_V_TOT]),
        .cnt     (v),
        .wrap    (v_wrap),
        .active  (v_act),
        .sync_on (v_sync)
    );

    assign copy      = pix_ce && h_wrap && v_wrap;
    assign de_next   = h_act && v_act;
    assign ra_max    = &v[CHAR_H_LOG2-1:0];
    assign char_cols = MA_W'(active[REG_H_ACT] >> CHAR_W_LOG2);

    // Copy reads the pre-write shadow, so a write on the copy cycle waits a frame
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            shadow <= REG_RST;
            active <= REG_RST;
        end else begin
            if (copy) begin
                active <= shadow;
            end
            if (bus.wr_en) begin
                shadow[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            row_base <= '0;
        end else if (pix_ce && h_wrap) begin
            if (v_wrap) begin
                row_base <= '0;
            end else if (ra_max) begin
                row_base <= row_base + char_cols;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            HSYNC       <= ~HS_POL;
            VSYNC       <= ~VS_POL;
            DE          <= 1'b0;
            x           <= '0;
            y           <= '0;
            MA          <= '0;
            RA          <= '0;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            HSYNC       <= sync_level(h_sync, HS_POL);
            VSYNC       <= sync_level(v_sync, VS_POL);
            DE          <= de_next;
            x           <= h;
            y           <= v;
            RA          <= v[CHAR_H_LOG2-1:0];
            frame_start <= (h == '0) && (v == '0);
            if (de_next) begin
                MA <= row_base + MA_W'(h >> CHAR_W_LOG2);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 16x8 timing with 2x2 character cells.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int unsigned CW   = 12;
    localparam int unsigned MA_W = 14;

    logic            CLK = 1'b0;
    logic            RSTn;
    logic            pix_ce;
    logic            HSYNC, VSYNC, DE, frame_start;
    logic [CW-1:0]   x, y;
    logic [MA_W-1:0] MA;
    logic [0:0]      RA;

    int checks   = 0;
    int failures = 0;
    int dot;

    always #5 CLK = ~CLK;

    vga_timing_gen_if #(.CW(CW)) bus ();

    vga_timing_gen #(
        .CW(CW), .H_ACT(8), .H_SS(10), .H_SE(12), .H_TOT(15),
        .V_ACT(4), .V_SS(5), .V_SE(6), .V_TOT(7),
        .HS_POL(POL_ACT_LOW), .VS_POL(POL_ACT_LOW),
        .CHAR_W_LOG2(1), .CHAR_H_LOG2(1), .MA_W(MA_W)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .pix_ce(pix_ce), .bus(bus),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE), .x(x), .y(y),
        .MA(MA), .RA(RA), .frame_start(frame_start)
    );

    typedef struct {
        int d; int ex; int ey; bit de; bit hs; bit vs; bit fs; int ma; int ra;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        logic ce_s;
        ce_s = pix_ce;
        @(posedge CLK);
        #1;
        if (ce_s) dot++;
    endtask

    task automatic run_to(input int t);
        while (dot < t) step();
    endtask

    // write is sampled on the edge where the counter sits on dot t
    task automatic wr_at(input int t, input reg_idx_e a, input int val);
        run_to(t - 1);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = CW'(val);
        run_to(t);
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        RSTn        = 1'b0;
        pix_ce      = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTn   = 1'b1;
        pix_ce = 1'b1;
        dot    = -1;
    endtask

    task automatic chk_pos(input string tag, input int ex, input int ey, input int efs);
        chk({tag, "_x"}, x, ex);
        chk({tag, "_y"}, y, ey);
        chk({tag, "_fs"}, frame_start, efs);
    endtask

    function automatic int mism(input int d);
        int h, v;
        h = d % 16;
        v = (d / 16) % 8;
        return int'((x != CW'(h)) || (y != CW'(v)) || (DE != (h < 8 && v < 4)) ||
                    (HSYNC != !(h >= 10 && h < 12)) || (VSYNC != (v != 5)) ||
                    (frame_start != (h == 0 && v == 0)));
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[$];
        int cnt_de, cnt_hs, cnt_vs, last_fs, fs_gap, bad, cyc, fs_prev;

        // reset state
        RSTn = 1'b0; pix_ce = 1'b1; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_de", DE, 0);   chk("rst_x", x, 0);     chk("rst_y", y, 0);
        chk("rst_ma", MA, 0);   chk("rst_ra", RA, 0);   chk("rst_fs", frame_start, 0);
        chk("rst_hs", HSYNC, 1); chk("rst_vs", VSYNC, 1);

        // free-run frame, vectors: d, x, y, de, hs, vs, fs, ma, ra
        tv.push_back('{0,   0, 0, 1, 1, 1, 1, 0, 0});
        tv.push_back('{1,   1, 0, 1, 1, 1, 0, 0, 0});
        tv.push_back('{3,   3, 0, 1, 1, 1, 0, 1, 0});
        tv.push_back('{7,   7, 0, 1, 1, 1, 0, 3, 0});
        tv.push_back('{8,   8, 0, 0, 1, 1, 0, 3, 0});
        tv.push_back('{10, 10, 0, 0, 0, 1, 0, 3, 0});
        tv.push_back('{11, 11, 0, 0, 0, 1, 0, 3, 0});
        tv.push_back('{12, 12, 0, 0, 1, 1, 0, 3, 0});
        tv.push_back('{15, 15, 0, 0, 1, 1, 0, 3, 0});
        tv.push_back('{16,  0, 1, 1, 1, 1, 0, 0, 1});
        tv.push_back('{23,  7, 1, 1, 1, 1, 0, 3, 1});
        tv.push_back('{32,  0, 2, 1, 1, 1, 0, 4, 0});
        tv.push_back('{39,  7, 2, 1, 1, 1, 0, 7, 0});
        tv.push_back('{48,  0, 3, 1, 1, 1, 0, 4, 1});
        tv.push_back('{63, 15, 3, 0, 1, 1, 0, 7, 1});
        tv.push_back('{64,  0, 4, 0, 1, 1, 0, 7, 0});
        tv.push_back('{80,  0, 5, 0, 1, 0, 0, 7, 1});
        tv.push_back('{95, 15, 5, 0, 1, 0, 0, 7, 1});
        tv.push_back('{96,  0, 6, 0, 1, 1, 0, 7, 0});
        tv.push_back('{127,15, 7, 0, 1, 1, 0, 7, 1});
        tv.push_back('{128, 0, 0, 1, 1, 1, 1, 0, 0});
        tv.push_back('{129, 1, 0, 1, 1, 1, 0, 0, 0});

        @(negedge CLK);
        RSTn = 1'b1;
        dot  = -1;
        for (int i = 0; i < tv.size(); i++) begin
            string tag;
            run_to(tv[i].d);
            tag = $sformatf("s1_d%0d", tv[i].d);
            chk({tag, "_x"}, x, tv[i].ex);
            chk({tag, "_y"}, y, tv[i].ey);
            chk({tag, "_de"}, DE, tv[i].de);
            chk({tag, "_hs"}, HSYNC, tv[i].hs);
            chk({tag, "_vs"}, VSYNC, tv[i].vs);
            chk({tag, "_fs"}, frame_start, tv[i].fs);
            chk({tag, "_ma"}, MA, tv[i].ma);
            chk({tag, "_ra"}, RA, tv[i].ra);
        end

        // two-frame aggregate counts
        do_reset();
        cnt_de = 0; cnt_hs = 0; cnt_vs = 0; last_fs = -1; fs_gap = 0;
        while (dot < 255) begin
            step();
            cnt_de += int'(DE);
            cnt_hs += int'(!HSYNC);
            cnt_vs += int'(!VSYNC);
            if (frame_start) begin
                if (last_fs >= 0) fs_gap = dot - last_fs;
                last_fs = dot;
            end
        end
        chk("s1_de_dots", cnt_de, 64);
        chk("s1_hs_dots", cnt_hs, 32);
        chk("s1_vs_dots", cnt_vs, 32);
        chk("s1_fs_period", fs_gap, 128);

        // pix_ce 1-of-4: outputs follow the enable count and hold between enables
        do_reset();
        bad = 0; last_fs = -1; fs_gap = 0; fs_prev = 0;
        for (cyc = 0; cyc < 4 * 140; cyc++) begin
            pix_ce = (cyc % 4 == 0);
            step();
            if (dot >= 0) bad += mism(dot);
            if (frame_start && !fs_prev) begin
                if (last_fs >= 0) fs_gap = cyc - last_fs;
                last_fs = cyc;
            end
            fs_prev = int'(frame_start);
        end
        pix_ce = 1'b1;
        chk("s2_mismatch_cycles", bad, 0);
        chk("s2_fs_period_clk", fs_gap, 512);

        // mid-frame H_TOT write applies at the next frame
        do_reset();
        wr_at(36, REG_H_TOT, 11);
        run_to(47);  chk_pos("s3_d47", 15, 2, 0);
        run_to(127); chk_pos("s3_d127", 15, 7, 0);
        run_to(128); chk_pos("s3_d128", 0, 0, 1);
        run_to(139); chk_pos("s3_d139", 11, 0, 0);
        run_to(140); chk_pos("s3_d140", 0, 1, 0);
        run_to(224); chk_pos("s3_d224", 0, 0, 1);

        // write on the copy cycle waits one frame; H_SS = H_SE suppresses HSYNC
        do_reset();
        wr_at(127, REG_H_TOT, 11);
        wr_at(130, REG_H_SS, 3);
        wr_at(131, REG_H_SS, 9);
        wr_at(132, REG_H_SE, 9);
        run_to(143); chk_pos("s4_d143", 15, 0, 0);
        cnt_hs = 0;
        while (dot < 255) begin
            step();
            cnt_hs += int'(!HSYNC);
        end
        chk("s4_f1_hs_dots", cnt_hs, 14);
        run_to(256); chk_pos("s4_d256", 0, 0, 1);
        cnt_hs = int'(!HSYNC);
        while (dot < 351) begin
            step();
            cnt_hs += int'(!HSYNC);
            if (dot == 267) chk_pos("s4_d267", 11, 0, 0);
            if (dot == 268) chk_pos("s4_d268", 0, 1, 0);
        end
        chk("s4_f2_hs_dots", cnt_hs, 0);
        run_to(352); chk_pos("s4_d352", 0, 0, 1);

        // H_TOT = 0: one-dot lines, 8-dot frames
        do_reset();
        wr_at(2, REG_H_TOT, 0);
        run_to(128); chk_pos("s7_d128", 0, 0, 1); chk("s7_d128_de", DE, 1);
        run_to(129); chk_pos("s7_d129", 0, 1, 0); chk("s7_d129_ma", MA, 0); chk("s7_d129_ra", RA, 1);
        run_to(130); chk_pos("s7_d130", 0, 2, 0); chk("s7_d130_ma", MA, 4); chk("s7_d130_ra", RA, 0);
        run_to(135); chk_pos("s7_d135", 0, 7, 0);
        run_to(136); chk_pos("s7_d136", 0, 0, 1); chk("s7_d136_ma", MA, 0);

        // reset mid-frame with a pending write
        do_reset();
        wr_at(20, REG_H_TOT, 11);
        run_to(52);
        chk_pos("s6_pre", 4, 3, 0);
        RSTn = 1'b0;
        #1;
        chk("s6_rst_x", x, 0);      chk("s6_rst_y", y, 0);
        chk("s6_rst_de", DE, 0);    chk("s6_rst_ma", MA, 0);
        chk("s6_rst_ra", RA, 0);    chk("s6_rst_fs", frame_start, 0);
        chk("s6_rst_hs", HSYNC, 1); chk("s6_rst_vs", VSYNC, 1);
        @(negedge CLK);
        RSTn = 1'b1;
        dot  = -1;
        run_to(0);   chk_pos("s6_d0", 0, 0, 1);
        run_to(15);  chk_pos("s6_d15", 15, 0, 0);
        run_to(16);  chk_pos("s6_d16", 0, 1, 0);
        run_to(128); chk_pos("s6_d128", 0, 0, 1);
        run_to(143); chk_pos("s6_d143", 15, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
